// File: rtl/axis_frame_arbiter.sv
// Two-source AXI4-Stream video arbiter; ownership changes only between whole frames.
// Latency: grant one cycle after a held SOF, then zero-latency combinational passthrough.
// Backpressure: m_axis_tready goes straight to the owner; non-owner SOFs are held, other beats drained.
module axis_frame_arbiter #(
    parameter int WIDTH          = 48,
    parameter int TUSER_WIDTH    = 1,
    parameter int LINES          = 1080,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   mode,
    input  logic                   s0_axis_tvalid,
    output logic                   s0_axis_tready,
    input  logic [WIDTH-1:0]       s0_axis_tdata,
    input  logic                   s0_axis_tlast,
    input  logic [TUSER_WIDTH-1:0] s0_axis_tuser,
    input  logic                   s1_axis_tvalid,
    output logic                   s1_axis_tready,
    input  logic [WIDTH-1:0]       s1_axis_tdata,
    input  logic                   s1_axis_tlast,
    input  logic [TUSER_WIDTH-1:0] s1_axis_tuser,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [WIDTH-1:0]       m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic [1:0]             grant,
    output logic                   frame_done,
    output logic                   timeout,
    output logic                   short_frame
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [15:0] LAST_LINE = 16'(LINES - 1);
    localparam logic [31:0] TO_LIMIT  = 32'(TIMEOUT_CYCLES);

    // Reset asserts asynchronously but releases on an aclk edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    state_t      state_q, state_d;
    logic        gsel_q, gsel_d;
    logic        last_grant_q, last_grant_d;
    logic        first_q, first_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        frame_done_q, frame_done_d;
    logic        timeout_q, timeout_d;
    logic        short_frame_q, short_frame_d;

    logic        active, hs, req0, req1, sof_mid, frame_end;
    logic [15:0] line_inc;
    logic [31:0] stall_inc;

    assign active = (state_q == ACTIVE);
    assign req0   = s0_axis_tvalid & s0_axis_tuser[0];
    assign req1   = s1_axis_tvalid & s1_axis_tuser[0];

    assign m_axis_tvalid = active & (gsel_q ? s1_axis_tvalid : s0_axis_tvalid);
    assign m_axis_tdata  = gsel_q ? s1_axis_tdata : s0_axis_tdata;
    assign m_axis_tlast  = gsel_q ? s1_axis_tlast : s0_axis_tlast;
    assign m_axis_tuser  = gsel_q ? s1_axis_tuser : s0_axis_tuser;

    // Anything not owning the output drains non-SOF beats and parks on SOF.
    assign s0_axis_tready = rst_n & ((active & ~gsel_q) ? m_axis_tready
                                                        : (s0_axis_tvalid & ~s0_axis_tuser[0]));
    assign s1_axis_tready = rst_n & ((active & gsel_q) ? m_axis_tready
                                                       : (s1_axis_tvalid & ~s1_axis_tuser[0]));

    assign grant       = active ? (gsel_q ? 2'b10 : 2'b01) : 2'b00;
    assign frame_done  = frame_done_q;
    assign timeout     = timeout_q;
    assign short_frame = short_frame_q;

    assign hs        = m_axis_tvalid & m_axis_tready;
    assign sof_mid   = hs & m_axis_tuser[0] & ~first_q;
    assign line_inc  = (&line_cnt_q)  ? line_cnt_q  : line_cnt_q + 16'd1;
    assign stall_inc = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + 32'd1;
    // A restarting SOF that also ends its line completes a frame only when frames are one line.
    assign frame_end = hs & m_axis_tlast &
                       (sof_mid ? (LAST_LINE == 16'd0) : (line_cnt_q == LAST_LINE));

    always_comb begin
        state_d       = state_q;
        gsel_d        = gsel_q;
        last_grant_d  = last_grant_q;
        first_d       = first_q;
        line_cnt_d    = line_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        frame_done_d  = 1'b0;
        timeout_d     = 1'b0;
        short_frame_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    state_d     = ACTIVE;
                    gsel_d      = (req0 & req1) ? (mode ? 1'b0 : ~last_grant_q) : req1;
                    first_d     = 1'b1;
                    line_cnt_d  = 16'd0;
                    stall_cnt_d = 32'd0;
                end
            end
            ACTIVE: begin
                if (hs) begin
                    stall_cnt_d = 32'd0;
                    first_d     = 1'b0;
                    if (frame_end) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                        last_grant_d = gsel_q;
                    end else if (sof_mid) begin
                        line_cnt_d    = {15'd0, m_axis_tlast};
                        short_frame_d = 1'b1;
                    end else if (m_axis_tlast) begin
                        line_cnt_d = line_inc;
                    end
                end else begin
                    stall_cnt_d = stall_inc;
                    if (TO_LIMIT != 32'd0 && stall_inc >= TO_LIMIT) begin
                        state_d      = IDLE;
                        timeout_d    = 1'b1;
                        last_grant_d = gsel_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            gsel_q        <= 1'b0;
            last_grant_q  <= 1'b1;
            first_q       <= 1'b0;
            line_cnt_q    <= 16'd0;
            stall_cnt_q   <= 32'd0;
            frame_done_q  <= 1'b0;
            timeout_q     <= 1'b0;
            short_frame_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gsel_q        <= gsel_d;
            last_grant_q  <= last_grant_d;
            first_q       <= first_d;
            line_cnt_q    <= line_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            frame_done_q  <= frame_done_d;
            timeout_q     <= timeout_d;
            short_frame_q <= short_frame_d;
        end
    end

endmodule
